// File: rtl/add_sub_pkg.sv
// add_sub_pkg: shared mode constants, checker state and default width for the adder/subtractor checker
package add_sub_pkg;
  localparam int DEF_WIDTH = 4;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
  typedef enum logic {CHK_RUN, CHK_HALT} chk_state_t;
endpackage

// File: rtl/add_sub_ref.sv
// add_sub_ref: combinational expected result (ans, carry/borrow, signed overflow) of the adder/subtractor
module add_sub_ref
  import add_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] ans,
  output logic             cy_br,
  output logic             ovf
);
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0] sum;
  assign b_eff = sub == MODE_SUB ? ~b : b;
  assign sum = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(sub);
  assign ans = sum[WIDTH-1:0];
  assign cy_br = sum[WIDTH] ^ sub;
  assign ovf = a[WIDTH-1] == b_eff[WIDTH-1] && ans[WIDTH-1] != a[WIDTH-1];
endmodule

// File: rtl/add_sub_checker.sv
// add_sub_checker: pipelined response checker with saturating pass/fail counts, first-fail capture and halt
module add_sub_checker
  import add_sub_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int CNT_W        = 8,
  parameter bit HALT_ON_FAIL = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLR,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  input  logic [WIDTH-1:0] ANS,
  input  logic             CY_BR,
  output logic             CHK_VALID,
  output logic             CHK_PASS,
  output logic [CNT_W-1:0] PASS_CNT,
  output logic [CNT_W-1:0] FAIL_CNT,
  output logic             FAIL_SEEN,
  output logic [WIDTH-1:0] FAIL_A,
  output logic [WIDTH-1:0] FAIL_B,
  output logic [WIDTH-1:0] FAIL_ANS,
  output logic             FAIL_SUB,
  output logic             FAIL_CY,
  output logic             OVF
);
  chk_state_t state, state_nx;
  logic acc, s2_fail;
  logic s1_v, s1_sub, s1_cy;
  logic [WIDTH-1:0] s1_a, s1_b, s1_ans;
  logic s2_v, s2_pass, s2_ovf, s2_sub, s2_cy;
  logic [WIDTH-1:0] s2_a, s2_b, s2_ans;
  logic [WIDTH-1:0] ref_ans;
  logic ref_cy, ref_ovf;
  assign IN_READY = RST_N && !CLR && state == CHK_RUN;
  assign acc = IN_VALID && IN_READY;
  assign s2_fail = s2_v && !s2_pass;
  always_comb state_nx = CLR ? CHK_RUN : (s2_fail && HALT_ON_FAIL) ? CHK_HALT : state;
  add_sub_ref #(.WIDTH(WIDTH)) u_ref (
    .a(s1_a), .b(s1_b), .sub(s1_sub), .ans(ref_ans), .cy_br(ref_cy), .ovf(ref_ovf)
  );
  // acc is already low during CLR, so S1 empties on its own; S2 needs the explicit flush
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= CHK_RUN;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s2_pass <= 1'b0;
      s2_ovf <= 1'b0;
      {s1_a, s1_b, s1_sub, s1_ans, s1_cy} <= '0;
      {s2_a, s2_b, s2_sub, s2_ans, s2_cy} <= '0;
    end else begin
      state <= state_nx;
      s1_v <= acc;
      s2_v <= s1_v && !CLR;
      if (acc) {s1_a, s1_b, s1_sub, s1_ans, s1_cy} <= {A, B, SUB, ANS, CY_BR};
      {s2_a, s2_b, s2_sub, s2_ans, s2_cy} <= {s1_a, s1_b, s1_sub, s1_ans, s1_cy};
      s2_pass <= ref_ans == s1_ans && ref_cy == s1_cy;
      s2_ovf <= ref_ovf;
    end
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      {CHK_VALID, CHK_PASS, OVF, FAIL_SEEN} <= '0;
      {PASS_CNT, FAIL_CNT} <= '0;
      {FAIL_A, FAIL_B, FAIL_ANS, FAIL_SUB, FAIL_CY} <= '0;
    end else if (CLR) begin
      {CHK_VALID, CHK_PASS, OVF, FAIL_SEEN} <= '0;
      {PASS_CNT, FAIL_CNT} <= '0;
      {FAIL_A, FAIL_B, FAIL_ANS, FAIL_SUB, FAIL_CY} <= '0;
    end else begin
      CHK_VALID <= s2_v;
      CHK_PASS <= s2_v && s2_pass;
      OVF <= s2_v && s2_ovf;
      if (s2_v && s2_pass && PASS_CNT != '1) PASS_CNT <= PASS_CNT + CNT_W'(1);
      if (s2_fail && FAIL_CNT != '1) FAIL_CNT <= FAIL_CNT + CNT_W'(1);
      FAIL_SEEN <= FAIL_SEEN || s2_fail;
      if (s2_fail && !FAIL_SEEN) {FAIL_A, FAIL_B, FAIL_ANS, FAIL_SUB, FAIL_CY} <= {s2_a, s2_b, s2_ans, s2_sub, s2_cy};
    end
  end
endmodule

// File: tb/tb_add_sub_checker.sv
// tb_add_sub_checker: randomized and directed checks of add_sub_checker against a transaction-level model
module tb_add_sub_checker;
  import add_sub_pkg::*;
  typedef struct {
    int         due;
    logic [3:0] a, b, ans;
    logic       sub, cy;
  } txn_t;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, in_valid = 1'b0, sub = 1'b0, cy_br = 1'b0;
  logic [3:0] a = '0, b = '0, ans = '0;
  logic in_ready, chk_valid, chk_pass, ovf, fail_seen, fail_sub, fail_cy;
  logic [7:0] pass_cnt, fail_cnt;
  logic [3:0] fail_a, fail_b, fail_ans;
  logic s_valid = 1'b0, s_sub = 1'b0, s_cy = 1'b0;
  logic [3:0] s_a = '0, s_b = '0, s_ans = '0;
  logic s_in_ready, s_chk_valid, s_chk_pass, s_ovf, s_fail_seen, s_fail_sub, s_fail_cy;
  logic [1:0] s_pass_cnt, s_fail_cnt;
  logic [3:0] s_fail_a, s_fail_b, s_fail_ans;
  int n_chk = 0, n_fail = 0, edge_n = 0;
  txn_t q[$];
  txn_t m_cap;
  int m_pass, m_fail;
  logic m_chk_v, m_chk_pass, m_ovf, m_seen, m_halt;
  always #5 clk = ~clk;
  add_sub_checker u_dut (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .IN_VALID(in_valid), .IN_READY(in_ready),
    .A(a), .B(b), .SUB(sub), .ANS(ans), .CY_BR(cy_br),
    .CHK_VALID(chk_valid), .CHK_PASS(chk_pass), .PASS_CNT(pass_cnt), .FAIL_CNT(fail_cnt),
    .FAIL_SEEN(fail_seen), .FAIL_A(fail_a), .FAIL_B(fail_b), .FAIL_ANS(fail_ans),
    .FAIL_SUB(fail_sub), .FAIL_CY(fail_cy), .OVF(ovf)
  );
  add_sub_checker #(.WIDTH(4), .CNT_W(2), .HALT_ON_FAIL(1'b0)) u_sat (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .IN_VALID(s_valid), .IN_READY(s_in_ready),
    .A(s_a), .B(s_b), .SUB(s_sub), .ANS(s_ans), .CY_BR(s_cy),
    .CHK_VALID(s_chk_valid), .CHK_PASS(s_chk_pass), .PASS_CNT(s_pass_cnt), .FAIL_CNT(s_fail_cnt),
    .FAIL_SEEN(s_fail_seen), .FAIL_A(s_fail_a), .FAIL_B(s_fail_b), .FAIL_ANS(s_fail_ans),
    .FAIL_SUB(s_fail_sub), .FAIL_CY(s_fail_cy), .OVF(s_ovf)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic void expect_of(input logic [3:0] xa, xb, input logic xs,
                                    output logic [3:0] e_ans, output logic e_cy, output logic e_ovf);
    int r, sa, sb, s;
    r = xs ? int'(xa) - int'(xb) : int'(xa) + int'(xb);
    e_ans = 4'(r);
    e_cy = xs ? xa < xb : r > 15;
    sa = xa[3] ? int'(xa) - 16 : int'(xa);
    sb = xb[3] ? int'(xb) - 16 : int'(xb);
    s = xs ? sa - sb : sa + sb;
    e_ovf = s > 7 || s < -8;
  endfunction
  function automatic void reset_model();
    q.delete();
    m_cap = '{default: '0};
    m_pass = 0;
    m_fail = 0;
    {m_chk_v, m_chk_pass, m_ovf, m_seen, m_halt} = '0;
  endfunction
  task automatic drive(input logic v, c, input logic [3:0] xa, xb, input logic xs,
                       input logic [3:0] xans, input logic xcy);
    txn_t t;
    logic acc, e_cy, e_ovf, ok;
    logic [3:0] e_ans;
    {in_valid, clr, a, b, sub, ans, cy_br} = {v, c, xa, xb, xs, xans, xcy};
    #1;
    check("in_ready", in_ready, !c && !m_halt);
    acc = v && !c && !m_halt;
    @(posedge clk);
    edge_n++;
    if (c) reset_model();
    else begin
      m_chk_v = 1'b0;
      if (q.size() != 0 && q[0].due == edge_n) begin
        t = q.pop_front();
        expect_of(t.a, t.b, t.sub, e_ans, e_cy, e_ovf);
        ok = e_ans == t.ans && e_cy == t.cy;
        {m_chk_v, m_chk_pass, m_ovf} = {1'b1, ok, e_ovf};
        if (ok && m_pass < 255) m_pass++;
        if (!ok && m_fail < 255) m_fail++;
        if (!ok && !m_seen) m_cap = t;
        if (!ok) {m_seen, m_halt} = 2'b11;
      end
      if (acc) begin
        t = '{due: edge_n + 2, a: xa, b: xb, ans: xans, sub: xs, cy: xcy};
        q.push_back(t);
      end
    end
    @(negedge clk);
    check("chk_valid", chk_valid, m_chk_v);
    if (m_chk_v) begin
      check("chk_pass", chk_pass, m_chk_pass);
      check("ovf", ovf, m_ovf);
    end
    check("pass_cnt", pass_cnt, m_pass);
    check("fail_cnt", fail_cnt, m_fail);
    check("fail_seen", fail_seen, m_seen);
    check("fail_a", fail_a, m_cap.a);
    check("fail_b", fail_b, m_cap.b);
    check("fail_ans", fail_ans, m_cap.ans);
    check("fail_sub", fail_sub, m_cap.sub);
    check("fail_cy", fail_cy, m_cap.cy);
  endtask
  task automatic idle();
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
  endtask
  task automatic rand_step(input logic v, c, input bit bad);
    logic [3:0] xa, xb, e_ans;
    logic xs, e_cy, e_ovf;
    xa = 4'($urandom);
    xb = 4'($urandom);
    xs = 1'($urandom);
    expect_of(xa, xb, xs, e_ans, e_cy, e_ovf);
    if (bad && $urandom_range(0, 1) == 0) e_ans ^= 4'($urandom_range(1, 15));
    else if (bad) e_cy = ~e_cy;
    drive(v, c, xa, xb, xs, e_ans, e_cy);
  endtask
  initial begin
    int s_pulses, s_passes;
    logic [3:0] e_ans;
    logic e_cy, e_ovf;
    reset_model();
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_chk_valid", chk_valid, 0);
    check("rst_pass_cnt", pass_cnt, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    check("rst_fail_seen", fail_seen, 0);
    check("rst_sat_ready", s_in_ready, 0);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 4'd7, 4'd1, MODE_ADD, 4'd8, 1'b0);
    drive(1'b1, 1'b0, 4'd7, 4'd15, MODE_ADD, 4'd6, 1'b1);
    drive(1'b1, 1'b0, 4'd9, 4'd1, MODE_SUB, 4'd8, 1'b0);
    drive(1'b1, 1'b0, 4'd0, 4'd1, MODE_SUB, 4'd15, 1'b1);
    drive(1'b1, 1'b0, 4'd0, 4'd8, MODE_SUB, 4'd8, 1'b1);
    drive(1'b1, 1'b0, 4'd7, 4'd7, MODE_ADD, 4'd15, 1'b0);
    drive(1'b1, 1'b0, 4'd3, 4'd2, MODE_ADD, 4'd9, 1'b0);
    drive(1'b1, 1'b0, 4'd1, 4'd1, MODE_ADD, 4'd2, 1'b0);
    repeat (3) drive(1'b1, 1'b0, 4'd2, 4'd2, MODE_ADD, 4'd4, 1'b0);
    check("halt_fail_ans", fail_ans, 15);
    check("halt_fail_cnt", fail_cnt, 2);
    drive(1'b0, 1'b1, 4'd0, 4'd0, MODE_ADD, 4'd0, 1'b0);
    drive(1'b1, 1'b0, 4'd1, 4'd2, MODE_ADD, 4'd3, 1'b0);
    drive(1'b1, 1'b0, 4'd5, 4'd3, MODE_SUB, 4'd2, 1'b0);
    drive(1'b0, 1'b1, 4'd0, 4'd0, MODE_ADD, 4'd0, 1'b0);
    repeat (3) idle();
    for (int i = 0; i < 400; i++)
      rand_step($urandom_range(0, 3) != 0, m_halt ? $urandom_range(0, 3) == 0 : $urandom_range(0, 49) == 0,
                $urandom_range(0, 11) == 0);
    drive(1'b0, 1'b1, 4'd0, 4'd0, MODE_ADD, 4'd0, 1'b0);
    s_pulses = 0;
    s_passes = 0;
    for (int i = 0; i < 8; i++) begin
      s_valid = i < 5;
      if (i == 0) {s_a, s_b, s_sub, s_ans, s_cy} = {4'd3, 4'd4, MODE_ADD, 4'd0, 1'b0};
      else begin
        s_a = 4'($urandom);
        s_b = 4'($urandom);
        s_sub = 1'($urandom);
        expect_of(s_a, s_b, s_sub, e_ans, e_cy, e_ovf);
        s_ans = e_ans ^ 4'h5;
        s_cy = e_cy;
      end
      idle();
      check("sat_ready", s_in_ready, 1);
      if (s_chk_valid) begin
        s_pulses++;
        if (s_chk_pass) s_passes++;
      end
    end
    check("sat_pulses", s_pulses, 5);
    check("sat_passes", s_passes, 0);
    check("sat_fail_cnt", s_fail_cnt, 3);
    check("sat_pass_cnt", s_pass_cnt, 0);
    check("sat_fail_seen", s_fail_seen, 1);
    check("sat_fail_a", s_fail_a, 3);
    check("sat_fail_b", s_fail_b, 4);
    check("sat_fail_ans", s_fail_ans, 0);
    check("sat_fail_sub", s_fail_sub, 0);
    check("sat_fail_cy", s_fail_cy, 0);
    drive(1'b1, 1'b0, 4'd2, 4'd3, MODE_ADD, 4'd5, 1'b0);
    drive(1'b1, 1'b0, 4'd4, 4'd1, MODE_ADD, 4'd5, 1'b0);
    drive(1'b1, 1'b0, 4'd6, 4'd2, MODE_SUB, 4'd4, 1'b0);
    drive(1'b1, 1'b0, 4'd8, 4'd3, MODE_SUB, 4'd5, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_chk_valid", chk_valid, 0);
    check("arst_pass_cnt", pass_cnt, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_fail_seen", fail_seen, 0);
    reset_model();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 4'd5, 4'd5, MODE_ADD, 4'd10, 1'b0);
    idle();
    check("post_rst_early", chk_valid, 0);
    idle();
    check("post_rst_pulse", chk_valid, 1);
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/add_sub_checker.md
# add_sub_checker

Synthesizable response checker for the 4-bit adder/subtractor: it is the receiving end of the operand stream that drives `ADD_SUB`.
- Each cycle it accepts one transaction: operands, mode, and the DUT's `ANS`/`CY_BR_OUT`.
- It recomputes the expected result in a 2-stage pipeline and compares.
- It keeps saturating pass/fail counts and captures the first mismatching transaction.
- It sits beside `ADD_SUB` on the FPGA self-test path, replacing visual waveform checks.

## Interface
Parameters:
- `WIDTH`, default 4: operand/result width.
- `CNT_W`, default 8: pass/fail counter width.
- `HALT_ON_FAIL`, default 1: when 1, stop accepting transactions after the first mismatch.

Ports:
- `CLK`  in  1  single clock, rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `CLR`  in  1  synchronous clear of counters, capture registers, pipeline and state.
- `IN_VALID`  in  1  transaction present.
- `IN_READY`  out  1  checker accepts when `IN_VALID & IN_READY`.
- `A`, `B`  in  WIDTH  operands.
- `SUB`  in  1  0 = add, 1 = subtract.
- `ANS`  in  WIDTH  DUT result.
- `CY_BR`  in  1  DUT carry (add) / borrow (sub).
- `CHK_VALID`  out  1  one-cycle pulse per completed check.
- `CHK_PASS`  out  1  result of that check; valid only with `CHK_VALID`.
- `PASS_CNT`, `FAIL_CNT`  out  CNT_W  saturating counts.
- `FAIL_SEEN`  out  1  sticky: at least one mismatch.
- `FAIL_A`, `FAIL_B`, `FAIL_ANS`  out  WIDTH  first failing transaction.
- `FAIL_SUB`, `FAIL_CY`  out  1  first failing transaction.
- `OVF`  out  1  signed overflow of the expected result; valid with `CHK_VALID`, informational only.

## Operation
Expected result:
- Add (`SUB=0`): WIDTH+1-bit `{cy, ans} = A + B`.
- Subtract (`SUB=1`): `{nbr, ans} = A + ~B + 1`; borrow = `~nbr`, i.e. 1 iff A < B unsigned.
- Pass iff `ans == ANS` and `cy/borrow == CY_BR`.
- `OVF`: operand signs as seen by the adder are equal and the result sign differs.

Pipeline:
- S1 registers the accepted transaction.
- S2 computes, compares, and registers `CHK_*`, the counters and the captures.

State machine (2 states):
- RUN: `IN_READY` = 1.
- HALT: `IN_READY` = 0. Entered on a registered mismatch when `HALT_ON_FAIL` = 1. Left only by `CLR` or reset.

Counters:
- `PASS_CNT` increments on a pass, `FAIL_CNT` on a fail.
- Both hold at all-ones (no wrap).

Capture:
- `FAIL_*` load only on the mismatch that sets `FAIL_SEEN`.
- Later mismatches never overwrite them.

`CLR`:
- Priority over everything.
- `IN_READY` = 0 during the `CLR` cycle.
- In-flight S1/S2 contents are discarded: no `CHK_VALID` is produced for them.
- Counters, captures and `FAIL_SEEN` go to 0; state goes to RUN.

Reset values:
- All outputs 0, including `IN_READY` while `RST_N` = 0.
- State is RUN after release, so `IN_READY` = 1 on the first cycle after deassertion.

## Timing
- Latency: accept at edge k → `CHK_VALID`, counters and captures update at edge k+2.
- Throughput: one transaction per cycle.
- Inputs are sampled only on accept; `ANS`/`CY_BR` must be valid in the same cycle as `A`/`B`/`SUB`.
- Halt timing: a mismatch registered at edge k+2 sets HALT at that edge.
  - Transactions accepted at k+1 and k+2 still complete and are counted.
  - They do not alter the captures.
  - No accept occurs after edge k+2.
- With `HALT_ON_FAIL` = 0, the state never leaves RUN.
- Reset asserted mid-operation: the pipeline is cleared immediately (asynchronous) and no pulse is emitted.

## Structure
- Shared package `add_sub_pkg`:
  - mode constants `MODE_ADD`/`MODE_SUB`;
  - checker state enum `CHK_RUN`/`CHK_HALT`;
  - default `WIDTH`.
- One natural sub-module, `add_sub_ref`: the combinational expected-result model (ans, cy/borrow, ovf), instantiated in S2.
- Counters and capture logic stay in the top level.

## Test plan
- Add passes:
  - A=7, B=1, SUB=0, ANS=8, CY=0 → `CHK_PASS`=1, `OVF`=1, `PASS_CNT`=1 two cycles after accept.
  - A=7, B=15, ANS=6, CY=1 → pass.
- Subtract passes:
  - A=9, B=1, SUB=1, ANS=8, BR=0 → pass.
  - A=0, B=1, ANS=15, BR=1 → pass.
  - A=0, B=8, ANS=8, BR=1 → pass, `OVF`=1.
- First fail capture and halt:
  - A=7, B=7, SUB=0, ANS=15 (expected 14) → `CHK_PASS`=0, `FAIL_SEEN`=1, `FAIL_ANS`=15, `FAIL_CNT`=1.
  - `IN_READY` falls at the same edge.
  - Back-to-back transactions at k+1 and k+2 still produce `CHK_VALID` and leave the captures unchanged.
- Saturation:
  - `CNT_W`=2, `HALT_ON_FAIL`=0, 5 failing transactions → `FAIL_CNT` = 3.
  - Captures hold the first transaction.
- `CLR` mid-flight: accept two transactions, assert `CLR` the next cycle → no `CHK_VALID`, counters 0, `IN_READY`=1 the cycle after `CLR`.
- Reset: drop `RST_N` with the pipeline full → all outputs 0 asynchronously; after release, first accept yields `CHK_VALID` exactly 2 cycles later.
